turf_prog_shifter: RTL and testbench

//  Parametrised TURF configuration/JTAG shifter. Drives TURF slave-serial configuration (DIN/CCLK/PROG_B)

---
 rtl/turf_prog_shifter.sv | 173 +++++++++++++++++
 tb/tb_turf_prog_shifter.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/turf_prog_shifter.sv
// TURF configuration/JTAG shifter: slave-serial DIN/CCLK before DONE, JTAG master
// (TCK/TMS/TDI, TDO capture) on the same pins afterwards or when CTRL[8] is set.
module turf_prog_shifter #(
  parameter int HALF_PERIOD = 8,
  parameter int SHIFT_WIDTH = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        prog_din_mtck_o,
  output logic        prog_cclk_o,
  output logic        prog_mtdi_o,
  output logic        prog_mtms_o,
  output logic        prog_mtms_oe_o,
  input  logic        prog_mtdo_i,
  input  logic        prog_done_i,
  output logic        prog_b_o,
  output logic        busy_o
);

  localparam int HW = SHIFT_WIDTH / 2;
  localparam int IW = (HW > 1) ? $clog2(HW) : 1;
  localparam int DW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  state_t                 state_q, state_d;
  logic [DW-1:0]          div_q;
  logic [SHIFT_WIDTH-1:0] sr_q;
  logic [HW-1:0]          cap_q;
  logic [4:0]             bit_cnt_q;
  logic [IW-1:0]          bit_idx_q;
  logic [4:0]             nbits_m1_q;
  logic                   mode_q;
  logic                   prog_q;
  logic                   done_latched_q;
  logic                   overrun_q;
  logic                   done_meta_q, done_sync_q;

  logic                   jtag_mode;
  logic                   phase_end;
  logic                   data_wr, ctrl_wr, busy_wr, status_wr;
  logic                   last_bit;
  logic [4:0]             eff_m1;
  logic [SHIFT_WIDTH-1:0] sr_shifted;

  assign jtag_mode = mode_q | done_latched_q;
  assign phase_end = (div_q == DW'(HALF_PERIOD - 1));
  assign data_wr   = wr_i && (addr_i == 2'd1) && (state_q == IDLE);
  assign ctrl_wr   = wr_i && (addr_i == 2'd0) && (state_q == IDLE);
  assign busy_wr   = wr_i && (addr_i inside {2'd0, 2'd1}) && (state_q != IDLE);
  assign status_wr = wr_i && (addr_i == 2'd3);
  assign last_bit  = (bit_cnt_q == 5'd0);
  assign busy_o    = (state_q != IDLE);

  // JTAG splits the register into a TDI half (low) and a TMS half (high).
  always_comb begin
    eff_m1 = nbits_m1_q;
    if (jtag_mode && (nbits_m1_q > 5'(HW - 1)))
      eff_m1 = 5'(HW - 1);
    if (jtag_mode)
      sr_shifted = {1'b0, sr_q[SHIFT_WIDTH-1:HW+1], 1'b0, sr_q[HW-1:1]};
    else
      sr_shifted = {1'b0, sr_q[SHIFT_WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (data_wr) state_d = LOW;
      LOW:     if (phase_end) state_d = HIGH;
      HIGH:    if (phase_end) state_d = last_bit ? IDLE : LOW;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      div_q     <= '0;
      sr_q      <= '0;
      cap_q     <= '0;
      bit_cnt_q <= '0;
      bit_idx_q <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) || phase_end)
        div_q <= '0;
      else
        div_q <= div_q + 1'b1;

      if (data_wr) begin
        sr_q      <= dat_i[SHIFT_WIDTH-1:0];
        cap_q     <= '0;
        bit_cnt_q <= eff_m1;
        bit_idx_q <= '0;
      end else if ((state_q == HIGH) && phase_end && !last_bit) begin
        sr_q      <= sr_shifted;
        bit_cnt_q <= bit_cnt_q - 1'b1;
      end

      // TDO is captured on the cycle TCK goes high internally.
      if ((state_q == LOW) && phase_end && jtag_mode) begin
        cap_q[bit_idx_q] <= prog_mtdo_i;
        bit_idx_q        <= bit_idx_q + 1'b1;
      end
    end
  end

  // DONE from the TURF wins over a software write of done_latched.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      nbits_m1_q     <= '0;
      mode_q         <= 1'b0;
      prog_q         <= 1'b0;
      done_latched_q <= 1'b0;
      overrun_q      <= 1'b0;
      done_meta_q    <= 1'b0;
      done_sync_q    <= 1'b0;
    end else begin
      done_meta_q <= prog_done_i;
      done_sync_q <= done_meta_q;
      if (ctrl_wr) begin
        nbits_m1_q <= dat_i[4:0];
        mode_q     <= dat_i[8];
        prog_q     <= dat_i[30];
      end
      if (done_sync_q)
        done_latched_q <= 1'b1;
      else if (ctrl_wr)
        done_latched_q <= dat_i[31];
      if (busy_wr)
        overrun_q <= 1'b1;
      else if (status_wr && dat_i[2])
        overrun_q <= 1'b0;
    end
  end

  // Pin registers meant for the IOBs; TMS/TDI only move while a JTAG shift runs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prog_din_mtck_o <= 1'b0;
      prog_cclk_o     <= 1'b0;
      prog_mtdi_o     <= 1'b0;
      prog_mtms_o     <= 1'b0;
      prog_mtms_oe_o  <= 1'b0;
      prog_b_o        <= 1'b1;
    end else begin
      prog_din_mtck_o <= jtag_mode ? (state_q == HIGH) : sr_q[0];
      prog_cclk_o     <= !jtag_mode && (state_q == HIGH);
      prog_mtms_oe_o  <= jtag_mode;
      prog_b_o        <= !prog_q;
      if (jtag_mode && (state_q != IDLE)) begin
        prog_mtdi_o <= sr_q[0];
        prog_mtms_o <= sr_q[HW];
      end
    end
  end

  always_comb begin
    dat_o = '0;
    case (addr_i)
      2'd0: dat_o = {done_latched_q, prog_q, 21'd0, mode_q, 3'd0, nbits_m1_q};
      2'd1: dat_o[SHIFT_WIDTH-1:0] = sr_q;
      2'd2: dat_o[HW-1:0] = cap_q;
      default: dat_o[3:0] = {jtag_mode, overrun_q, done_sync_q, busy_o};
    endcase
  end

endmodule

// File: tb/tb_turf_prog_shifter.sv
// Scoreboard bench for turf_prog_shifter: expected pin bits are queued at DATA write
// time and popped against the bits seen on each bit-clock rising edge.
module tb_turf_prog_shifter;

  localparam int HP = 2;
  localparam int SW = 32;

  logic        clk = 1'b0;
  logic        rst_i, wr_i;
  logic [1:0]  addr_i;
  logic [31:0] dat_i, dat_o;
  logic        prog_din_mtck_o, prog_cclk_o, prog_mtdi_o, prog_mtms_o, prog_mtms_oe_o;
  logic        prog_mtdo_i, prog_done_i, prog_b_o, busy_o;

  int vectors = 0;
  int miscompares = 0;

  logic exp_d[$], exp_t[$], obs_d[$], obs_t[$];
  int   pulses, busy_cycles;
  bit   cclk_in_jtag, spacing_bad, timed_out;

  always #5 clk = ~clk;

  // TDO looped back to TDI
  assign prog_mtdo_i = prog_mtdi_o;

  turf_prog_shifter #(.HALF_PERIOD(HP), .SHIFT_WIDTH(SW)) dut (
    .clk_i(clk), .rst_i(rst_i), .wr_i(wr_i), .addr_i(addr_i), .dat_i(dat_i), .dat_o(dat_o),
    .prog_din_mtck_o(prog_din_mtck_o), .prog_cclk_o(prog_cclk_o), .prog_mtdi_o(prog_mtdi_o),
    .prog_mtms_o(prog_mtms_o), .prog_mtms_oe_o(prog_mtms_oe_o), .prog_mtdo_i(prog_mtdo_i),
    .prog_done_i(prog_done_i), .prog_b_o(prog_b_o), .busy_o(busy_o)
  );

  task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    addr_i = a; dat_i = d; wr_i = 1'b1;
    @(negedge clk);
    wr_i = 1'b0;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    addr_i = a; wr_i = 1'b0;
    #1 d = dat_o;
  endtask

  function automatic void push_bits(input logic [31:0] tdi, input logic [31:0] tms, input int n);
    for (int i = 0; i < n; i++) begin
      exp_d.push_back(tdi[i]);
      exp_t.push_back(tms[i]);
    end
  endfunction

  // Runs one transfer (write already done), collecting pin bits at each bit-clock rise.
  task automatic watch(input bit jtag, input bit inject, input int inj_cyc, input logic [31:0] inj_dat);
    int   cyc;
    int   last;
    logic bclk, prev;
    obs_d.delete(); obs_t.delete();
    pulses = 0; busy_cycles = 0; cclk_in_jtag = 0; spacing_bad = 0; timed_out = 1;
    last = -1;
    prev = jtag ? prog_din_mtck_o : prog_cclk_o;
    for (cyc = 0; cyc < 2000; cyc++) begin
      bclk = jtag ? prog_din_mtck_o : prog_cclk_o;
      if (jtag && prog_cclk_o) cclk_in_jtag = 1;
      if (bclk && !prev) begin
        pulses++;
        obs_d.push_back(jtag ? prog_mtdi_o : prog_din_mtck_o);
        obs_t.push_back(prog_mtms_o);
        if (last >= 0 && (cyc - last) != 2 * HP) spacing_bad = 1;
        last = cyc;
      end
      prev = bclk;
      if (busy_o) busy_cycles++;
      else if (cyc > 0) begin
        timed_out = 0;
        break;
      end
      wr_i = inject && (cyc == inj_cyc);
      addr_i = 2'd1; dat_i = inj_dat;
      @(negedge clk);
    end
    wr_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    @(negedge clk);
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    vectors++;
    if ({prog_din_mtck_o, prog_cclk_o, prog_mtdi_o, prog_mtms_o, prog_mtms_oe_o, prog_b_o, busy_o} !== 7'b0000010) begin
      miscompares++;
      $display("[TB] FAIL reset_pins: got %b want 0000010",
               {prog_din_mtck_o, prog_cclk_o, prog_mtdi_o, prog_mtms_o, prog_mtms_oe_o, prog_b_o, busy_o});
    end
    for (int a = 0; a < 4; a++) begin
      read_reg(2'(a), r);
      vectors++;
      if (r !== 32'h0) begin
        miscompares++;
        $display("[TB] FAIL reset_reg%0d: got %h want 00000000", a, r);
      end
    end
  endtask

  task automatic test_serial();
    logic [31:0] r;
    logic e, o;
    write_reg(2'd0, 32'h0000_0007);
    push_bits(32'hA5, 32'h0, 8);
    exp_t.delete();
    write_reg(2'd1, 32'h0000_00A5);
    watch(1'b0, 1'b0, 0, 32'h0);
    vectors++;
    if (timed_out || pulses != 8) begin
      miscompares++;
      $display("[TB] FAIL serial_pulses: got %0d (timeout %0d) want 8", pulses, timed_out);
    end
    vectors++;
    if (busy_cycles != 2 * HP * 8) begin
      miscompares++;
      $display("[TB] FAIL serial_busy: got %0d want %0d", busy_cycles, 2 * HP * 8);
    end
    vectors++;
    if (spacing_bad) begin
      miscompares++;
      $display("[TB] FAIL serial_spacing: CCLK rises not %0d cycles apart", 2 * HP);
    end
    while (exp_d.size() > 0) begin
      e = exp_d.pop_front();
      o = (obs_d.size() > 0) ? obs_d.pop_front() : 1'bx;
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("[TB] FAIL serial_din: got %b want %b", o, e);
      end
    end
    read_reg(2'd1, r);
    vectors++;
    if (r !== 32'h1) begin
      miscompares++;
      $display("[TB] FAIL serial_data_read: got %h want 00000001", r);
    end
    read_reg(2'd3, r);
    vectors++;
    if (r !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL serial_status: got %h want 00000000", r);
    end
  endtask

  task automatic test_overrun();
    logic [31:0] r;
    logic e, o;
    push_bits(32'hA5, 32'h0, 8);
    exp_t.delete();
    write_reg(2'd1, 32'h0000_00A5);
    watch(1'b0, 1'b1, 10, 32'h0000_00FF);
    vectors++;
    if (timed_out || pulses != 8) begin
      miscompares++;
      $display("[TB] FAIL overrun_pulses: got %0d want 8", pulses);
    end
    while (exp_d.size() > 0) begin
      e = exp_d.pop_front();
      o = (obs_d.size() > 0) ? obs_d.pop_front() : 1'bx;
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("[TB] FAIL overrun_din: got %b want %b", o, e);
      end
    end
    read_reg(2'd3, r);
    vectors++;
    if (r !== 32'h4) begin
      miscompares++;
      $display("[TB] FAIL overrun_set: got %h want 00000004", r);
    end
    write_reg(2'd3, 32'h4);
    read_reg(2'd3, r);
    vectors++;
    if (r !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL overrun_clear: got %h want 00000000", r);
    end
  endtask

  task automatic test_jtag(input logic [31:0] ctrl, input logic [31:0] data, input int n,
                           input logic [31:0] tdo_exp, input bit check_data, input logic [31:0] data_exp);
    logic [31:0] r;
    logic e, o;
    write_reg(2'd0, ctrl);
    read_reg(2'd0, r);
    vectors++;
    if (r !== ctrl) begin
      miscompares++;
      $display("[TB] FAIL jtag_ctrl_read: got %h want %h", r, ctrl);
    end
    vectors++;
    if (prog_mtms_oe_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL jtag_oe: got %b want 1", prog_mtms_oe_o);
    end
    push_bits(data, data >> (SW / 2), n);
    write_reg(2'd1, data);
    watch(1'b1, 1'b0, 0, 32'h0);
    vectors++;
    if (timed_out || pulses != n) begin
      miscompares++;
      $display("[TB] FAIL jtag_pulses: got %0d want %0d", pulses, n);
    end
    vectors++;
    if (busy_cycles != 2 * HP * n || cclk_in_jtag) begin
      miscompares++;
      $display("[TB] FAIL jtag_busy_cclk: busy %0d want %0d, cclk_seen %0d want 0",
               busy_cycles, 2 * HP * n, cclk_in_jtag);
    end
    while (exp_d.size() > 0) begin
      e = exp_d.pop_front();
      o = (obs_d.size() > 0) ? obs_d.pop_front() : 1'bx;
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("[TB] FAIL jtag_tdi: got %b want %b", o, e);
      end
      e = exp_t.pop_front();
      o = (obs_t.size() > 0) ? obs_t.pop_front() : 1'bx;
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("[TB] FAIL jtag_tms: got %b want %b", o, e);
      end
    end
    read_reg(2'd2, r);
    vectors++;
    if (r !== tdo_exp) begin
      miscompares++;
      $display("[TB] FAIL jtag_tdo: got %h want %h", r, tdo_exp);
    end
    if (check_data) begin
      read_reg(2'd1, r);
      vectors++;
      if (r !== data_exp) begin
        miscompares++;
        $display("[TB] FAIL jtag_data_read: got %h want %h", r, data_exp);
      end
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [31:0] r;
    logic e, o;
    int rises;
    logic prev;
    write_reg(2'd0, 32'h4000_0007);
    read_reg(2'd3, r);
    vectors++;
    if (prog_b_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL prog_b_low: got %b want 0", prog_b_o);
    end
    write_reg(2'd1, 32'h0000_00A5);
    rises = 0; prev = prog_cclk_o;
    for (int c = 0; c < 200 && rises < 3; c++) begin
      if (prog_cclk_o && !prev) rises++;
      prev = prog_cclk_o;
      if (rises < 3) @(negedge clk);
    end
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    vectors++;
    if (rises != 3 || busy_o !== 1'b0 || prog_b_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_mid: rises %0d want 3, busy %b want 0, prog_b %b want 1", rises, busy_o, prog_b_o);
    end
    rises = 0; prev = prog_cclk_o;
    repeat (20) begin
      @(negedge clk);
      if (prog_cclk_o && !prev) rises++;
      prev = prog_cclk_o;
    end
    vectors++;
    if (rises != 0 || prog_cclk_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_edges: got %0d rises want 0", rises);
    end
    write_reg(2'd0, 32'h0000_0007);
    push_bits(32'h3C, 32'h0, 8);
    exp_t.delete();
    write_reg(2'd1, 32'h0000_003C);
    watch(1'b0, 1'b0, 0, 32'h0);
    vectors++;
    if (timed_out || pulses != 8) begin
      miscompares++;
      $display("[TB] FAIL reset_resume_pulses: got %0d want 8", pulses);
    end
    while (exp_d.size() > 0) begin
      e = exp_d.pop_front();
      o = (obs_d.size() > 0) ? obs_d.pop_front() : 1'bx;
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("[TB] FAIL reset_resume_din: got %b want %b", o, e);
      end
    end
  endtask

  task automatic test_done();
    logic [31:0] r;
    logic e, o;
    write_reg(2'd0, 32'h0000_0007);
    read_reg(2'd0, r);
    vectors++;
    if (r !== 32'h7 || prog_mtms_oe_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL pre_done: ctrl %h want 00000007, oe %b want 0", r, prog_mtms_oe_o);
    end
    prog_done_i = 1'b1;
    r = 32'h0;
    for (int i = 0; i < 10 && !r[31]; i++) read_reg(2'd0, r);
    @(negedge clk);
    vectors++;
    if (r !== 32'h8000_0007) begin
      miscompares++;
      $display("[TB] FAIL done_ctrl: got %h want 80000007", r);
    end
    read_reg(2'd3, r);
    vectors++;
    if (r !== 32'hA || prog_mtms_oe_o !== 1'b1 || prog_cclk_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL done_status: got %h want 0000000a, oe %b want 1, cclk %b want 0",
               r, prog_mtms_oe_o, prog_cclk_o);
    end
    push_bits(32'h34, 32'hAB, 8);
    write_reg(2'd1, 32'h00AB_0034);
    watch(1'b1, 1'b0, 0, 32'h0);
    vectors++;
    if (timed_out || pulses != 8 || cclk_in_jtag) begin
      miscompares++;
      $display("[TB] FAIL done_jtag: pulses %0d want 8, cclk_seen %0d want 0", pulses, cclk_in_jtag);
    end
    while (exp_d.size() > 0) begin
      e = exp_d.pop_front();
      o = (obs_d.size() > 0) ? obs_d.pop_front() : 1'bx;
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("[TB] FAIL done_tdi: got %b want %b", o, e);
      end
      e = exp_t.pop_front();
      o = (obs_t.size() > 0) ? obs_t.pop_front() : 1'bx;
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("[TB] FAIL done_tms: got %b want %b", o, e);
      end
    end
  endtask

  initial begin
    rst_i = 1'b1; wr_i = 1'b0; addr_i = 2'd0; dat_i = 32'h0; prog_done_i = 1'b0;
    test_reset();
    test_serial();
    test_overrun();
    test_jtag(32'h0000_0104, 32'h001F_000A, 5, 32'h0000_000A, 1'b1, 32'h0001_0000);
    test_jtag(32'h0000_011F, 32'hC3A5_5A3C, 16, 32'h0000_5A3C, 1'b0, 32'h0);
    test_reset_mid_shift();
    test_done();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
